fetch_prefetch_unit: RTL and testbench

- Instruction-fetch front end for the 5-stage pipelined processor; sits directly upstream of the IF/ID segment register.
- Owns the fetch PC and issues word-addressed requests to instruction memory (PC increments by 1).
- Buffers returned instructions with their PCs in a small FIFO; presents them to ID with a valid/ready handshake.
- Handles branch/jump redirects from EX by flushing the FIFO and discarding any in-flight response.

---
 rtl/fetch_prefetch_unit.sv | 176 +++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction-fetch front end ahead of the IF/ID register.
// Owns the fetch PC, issues word-addressed requests to instruction memory,
// buffers {pc, instr} pairs in a DEPTH-entry FIFO and hands them to ID with
// a valid/ready handshake. A redirect from EX flushes the FIFO and discards
// any response still in flight.
//
// Optional build macro: FETCH_STATS_EN adds saturating stat_fetched and
// stat_flushed counters.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   start                       begin fetching (pulse or level)
//   imem_req/imem_addr          request to instruction memory, held until ack
//   imem_ack/imem_rdata         response strobe and instruction word
//   redirect_valid/redirect_pc  taken branch/jump from EX
//   if_valid/if_instr/if_pc     FIFO head presented to ID
//   id_ready                    ID accepts the head this cycle
//   stat_fetched/stat_flushed   (FETCH_STATS_EN only) event counters
module fetch_prefetch_unit #(
  parameter int              DEPTH    = 4,
  parameter int              DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] if_pc,
  input  logic              id_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushed
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                imem_req_q, imem_req_d;
  logic [DATA_W-1:0]   imem_addr_q, imem_addr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  logic [DEPTH-1:0][DATA_W-1:0] instr_mem_q;
  logic [DEPTH-1:0][DATA_W-1:0] pc_mem_q;

  logic push, pop;

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

  // A redirect hides the head so ID never consumes a wrong-path instruction.
  assign if_valid = (count_q != '0) && !redirect_valid;
  assign if_instr = (count_q != '0) ? instr_mem_q[rd_ptr_q] : '0;
  assign if_pc    = (count_q != '0) ? pc_mem_q[rd_ptr_q]    : '0;

  assign push = (state_q == REQ) && imem_ack && !redirect_valid;
  assign pop  = if_valid && id_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        fetch_pc_d = fetch_pc_q + DATA_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    unique case (state_q)
      IDLE: if (start && !redirect_valid) state_d = REQ;
      REQ: begin
        if (redirect_valid)   state_d = imem_ack ? REQ : DROP;
        else if (imem_ack)    state_d = (count_d < CW'(DEPTH)) ? REQ : HOLD;
      end
      HOLD: begin
        if (redirect_valid || (count_d < CW'(DEPTH))) state_d = REQ;
      end
      // The abandoned request completes on its ack even if another redirect
      // lands that cycle; fetch_pc already holds the newest target.
      DROP: if (imem_ack) state_d = REQ;
      default: state_d = IDLE;
    endcase

    imem_req_d = (state_d == REQ) || (state_d == DROP);
    // DROP keeps presenting the abandoned address until memory answers it.
    if (state_d == DROP)
      imem_addr_d = (state_q == DROP) ? imem_addr_q : fetch_pc_q;
    else
      imem_addr_d = fetch_pc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_flushed_q, stat_flushed_d;
  logic        discard_rsp;
  logic [32:0] fetched_sum, flushed_sum;

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;

  // A response is thrown away when it returns under a redirect or in DROP.
  assign discard_rsp = imem_ack &&
                       (((state_q == REQ) && redirect_valid) || (state_q == DROP));

  always_comb begin
    fetched_sum = {1'b0, stat_fetched_q} + 33'(push);
    flushed_sum = {1'b0, stat_flushed_q} + 33'(discard_rsp);
    if (redirect_valid) flushed_sum = flushed_sum + 33'd1 + 33'(count_q);
    stat_fetched_d = fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
    stat_flushed_d = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_flushed_q <= stat_flushed_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed testbench for fetch_prefetch_unit. A behavioural memory answers
// requests with rdata = addr + 100 in one of three modes: never ack,
// zero-wait (ack in the request cycle) or ack in the fourth request cycle.
module tb_fetch_prefetch_unit;

  logic        clk, rst, start;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, id_ready;
  logic [31:0] if_instr, if_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] mem_mode;  // 0 none, 1 zero-wait, 2 three wait cycles
  logic [1:0] wait_cnt;

  fetch_prefetch_unit #(.DEPTH(4), .DATA_W(32), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst)                       wait_cnt <= 2'd0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 2'd1;
    else                            wait_cnt <= 2'd0;
  end

  assign imem_ack   = imem_req && ((mem_mode == 2'd1) ||
                                   ((mem_mode == 2'd2) && (wait_cnt == 2'd3)));
  assign imem_rdata = imem_addr + 32'd100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    id_ready = 1'b0;
    mem_mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc",    if_pc, 32'd0);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    mem_mode = 2'd0;

    // 1: streaming with zero-wait memory
    do_reset();
    mem_mode = 2'd1; id_ready = 1'b1; start = 1'b1;
    #1 chk("t1_valid_start", {31'd0, if_valid}, 32'd0);
    tick(); start = 1'b0;
    chk("t1_req",   {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'd0);
    chk("t1_valid_req", {31'd0, if_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_valid", {31'd0, if_valid}, 32'd1);
      chk("t1_pc",    if_pc, 32'(i));
      chk("t1_instr", if_instr, 32'(100 + i));
    end

    // 2: fill to full, HOLD, then one pop restarts fetch at 4
    do_reset();
    mem_mode = 2'd1; id_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
    chk("t2_head_pc",  if_pc, 32'd0);
    tick();
    chk("t2_hold_req2", {31'd0, imem_req}, 32'd0);
    id_ready = 1'b1;
    tick(); id_ready = 1'b0;
    chk("t2_pop_pc",   if_pc, 32'd1);
    chk("t2_rereq",    {31'd0, imem_req}, 32'd1);
    chk("t2_readdr",   imem_addr, 32'd4);
    tick();
    chk("t2_full_again", {31'd0, imem_req}, 32'd0);

    // 3: redirect while a slow request is outstanding
    do_reset();
    mem_mode = 2'd2; id_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1 chk("t3_valid_redir", {31'd0, if_valid}, 32'd0);
    tick(); redirect_valid = 1'b0;
    chk("t3_drop_req",  {31'd0, imem_req}, 32'd1);
    chk("t3_drop_addr", imem_addr, 32'd0);
    tick();
    chk("t3_drop_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("t3_new_addr",  imem_addr, 32'h40);
    chk("t3_no_push",   {31'd0, if_valid}, 32'd0);
    begin
      int n = 0;
      while (!if_valid && n < 20) begin tick(); n++; end
      if (n >= 20) chk("t3_timeout", 32'd0, 32'd1);
    end
    chk("t3_first_pc",    if_pc, 32'h40);
    chk("t3_first_instr", if_instr, 32'h40 + 32'd100);

    // 4: redirect coinciding with ack and a would-be pop
    do_reset();
    mem_mode = 2'd1; id_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("t4_head0", if_pc, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    #1 chk("t4_valid_redir", {31'd0, if_valid}, 32'd0);
    tick(); redirect_valid = 1'b0;
    chk("t4_empty", {31'd0, if_valid}, 32'd0);
    chk("t4_req",   {31'd0, imem_req}, 32'd1);
    chk("t4_addr",  imem_addr, 32'h80);
    tick();
    chk("t4_pc",    if_pc, 32'h80);
    chk("t4_instr", if_instr, 32'h80 + 32'd100);

    // 5: async reset while a request at 7 is pending
    do_reset();
    mem_mode = 2'd1; id_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'd5;
    tick(); redirect_valid = 1'b0;
    chk("t5_idle_req", {31'd0, imem_req}, 32'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t5_addr5", imem_addr, 32'd5);
    tick(); tick();
    mem_mode = 2'd0;
    #1;
    chk("t5_addr7", imem_addr, 32'd7);
    chk("t5_req7",  {31'd0, imem_req}, 32'd1);
    chk("t5_head",  if_pc, 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_req",   {31'd0, imem_req}, 32'd0);
    chk("t5_rst_addr",  imem_addr, 32'd0);
    chk("t5_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("t5_rst_instr", if_instr, 32'd0);
    chk("t5_rst_pc",    if_pc, 32'd0);
    @(posedge clk); #1 rst = 1'b1; mem_mode = 2'd1;
    repeat (3) tick();
    chk("t5_no_fetch", {31'd0, imem_req}, 32'd0);
    chk("t5_no_valid", {31'd0, if_valid}, 32'd0);

`ifdef FETCH_STATS_EN
    // 6: 10 fetches, 3 left buffered, then a redirect
    do_reset();
    mem_mode = 2'd1; start = 1'b1;
    tick(); start = 1'b0; id_ready = 1'b1;
    repeat (8) tick();
    id_ready = 1'b0;
    repeat (2) tick();
    mem_mode = 2'd0;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick(); redirect_valid = 1'b0;
    chk("t6_fetched", stat_fetched, 32'd10);
    chk("t6_flushed", stat_flushed, 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
